// File: rtl/vsmac_pkg.sv
// Shared definitions for the vsmac datapath and its sequencers.
package vsmac_pkg;

  localparam int VSMAC_SIZE   = 3;
  localparam int VSMAC_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    HOLD
  } seq_state_t;

endpackage

// File: rtl/vsmac.sv
// SIZE-lane signed multiply-accumulate: a product stage followed by an
// accumulate stage, so an enable cycle shows on out two cycles later.
module vsmac #(
  parameter int SIZE   = vsmac_pkg::VSMAC_SIZE,
  parameter int DATA_W = vsmac_pkg::VSMAC_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [SIZE*DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]        b,
  output logic [SIZE*DATA_W-1:0]   out
);

  logic signed [2*DATA_W-1:0] p_full [SIZE];
  logic        [DATA_W-1:0]   prod   [SIZE];
  logic        [DATA_W-1:0]   acc    [SIZE];
  logic                       en1;

  // Full-width signed lane products; only the low DATA_W bits are kept.
  always_comb begin
    for (int unsigned i = 0; i < SIZE; i++) begin
      p_full[i] = $signed(a[i*DATA_W +: DATA_W]) * $signed(b);
    end
  end

  // Product register then wrapping accumulator, both cleared synchronously.
  always_ff @(posedge clk) begin
    if (reset) begin
      en1 <= 1'b0;
      for (int unsigned i = 0; i < SIZE; i++) begin
        prod[i] <= '0;
        acc[i]  <= '0;
      end
    end else begin
      en1 <= enable;
      for (int unsigned i = 0; i < SIZE; i++) begin
        prod[i] <= p_full[i][DATA_W-1:0];
        if (en1) acc[i] <= acc[i] + prod[i];
      end
    end
  end

  // Pack lane accumulators onto the output bus, lane 0 in the low bits.
  always_comb begin
    for (int unsigned i = 0; i < SIZE; i++) begin
      out[i*DATA_W +: DATA_W] = acc[i];
    end
  end

endmodule

// File: rtl/vsmac_sequencer_delay_line.sv
// Fixed-depth shift register used to align control strobes with data.
module delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [DEPTH-1:0][WIDTH-1:0] sr;

  // Shift d through DEPTH register stages.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr <= '0;
    end else begin
      sr[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/vsmac_sequencer.sv
// Drives one vsmac through y = W*x: clear, stream len columns, drain the
// pipeline, then hold the product behind a valid/ready handshake.
module vsmac_sequencer
  import vsmac_pkg::*;
#(
  parameter int SIZE     = vsmac_pkg::VSMAC_SIZE,
  parameter int DATA_W   = vsmac_pkg::VSMAC_DATA_W,
  parameter int K_MAX    = 16,
  parameter int ADDR_W   = 4,
  parameter int PIPE_LAT = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [ADDR_W:0]        len,
  output logic                   busy,
  output logic                   rd_en,
  output logic [ADDR_W-1:0]      rd_addr,
  input  logic [SIZE*DATA_W-1:0] w_rdata,
  input  logic [DATA_W-1:0]      x_rdata,
  output logic                   mac_clear,
  output logic                   mac_enable,
  output logic [SIZE*DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0]      mac_b,
  input  logic [SIZE*DATA_W-1:0] mac_out,
  output logic [SIZE*DATA_W-1:0] result,
  output logic                   result_valid,
  input  logic                   result_ready
);

  typedef logic [ADDR_W:0] cnt_t;

  localparam cnt_t CNT_ONE  = cnt_t'(1);
  localparam cnt_t CNT_KMAX = cnt_t'(K_MAX);
  localparam cnt_t CNT_LAT  = cnt_t'(PIPE_LAT);

  seq_state_t            state_q, state_d;
  cnt_t                  cnt_q, cnt_d;
  cnt_t                  len_q, len_d;
  logic [SIZE*DATA_W-1:0] result_q, result_d;
  logic                  valid_q, valid_d;

  // State, counter, latched length and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  // Next-state and buffer/vsmac control decode. One counter serves both the
  // column index in STREAM and the drain count in DRAIN.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    result_d  = result_q;
    valid_d   = valid_q;
    rd_en     = 1'b0;
    rd_addr   = '0;
    mac_clear = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = (len > CNT_KMAX) ? CNT_KMAX : len;
          cnt_d   = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        mac_clear = 1'b1;
        cnt_d     = '0;
        state_d   = (len_q != '0) ? STREAM : DRAIN;
      end
      STREAM: begin
        rd_en   = 1'b1;
        rd_addr = cnt_q[ADDR_W-1:0];
        if (cnt_q == len_q - CNT_ONE) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DRAIN: begin
        if (cnt_q == CNT_LAT) begin
          result_d = mac_out;
          valid_d  = 1'b1;
          cnt_d    = '0;
          state_d  = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HOLD: begin
        if (result_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Buffers return data one cycle after rd_en; delay the issue strobe to match.
  delay_line #(
    .DEPTH(1),
    .WIDTH(1)
  ) u_issue_dly (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rd_en),
    .q       (mac_enable)
  );

  // Operands pass straight through only on issue cycles.
  always_comb begin
    mac_a = mac_enable ? w_rdata : '0;
    mac_b = mac_enable ? x_rdata : '0;
  end

  assign busy         = (state_q != IDLE);
  assign result       = result_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_vsmac_sequencer.sv
// Directed bench for vsmac_sequencer driving a real vsmac.
module tb_vsmac_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [4:0]  len;
  logic        busy;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [23:0] w_rdata = '0;
  logic [7:0]  x_rdata = '0;
  logic        mac_clear;
  logic        mac_enable;
  logic [23:0] mac_a;
  logic [7:0]  mac_b;
  logic [23:0] mac_out;
  logic [23:0] result;
  logic        result_valid;
  logic        result_ready;

  logic [23:0] wbuf [16];
  logic [7:0]  xbuf [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vsmac_sequencer #(
    .SIZE(3), .DATA_W(8), .K_MAX(16), .ADDR_W(4), .PIPE_LAT(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .len(len), .busy(busy),
    .rd_en(rd_en), .rd_addr(rd_addr), .w_rdata(w_rdata), .x_rdata(x_rdata),
    .mac_clear(mac_clear), .mac_enable(mac_enable), .mac_a(mac_a),
    .mac_b(mac_b), .mac_out(mac_out), .result(result),
    .result_valid(result_valid), .result_ready(result_ready)
  );

  vsmac #(.SIZE(3), .DATA_W(8)) u_mac (
    .clk(clk), .reset(mac_clear), .enable(mac_enable),
    .a(mac_a), .b(mac_b), .out(mac_out)
  );

  // Synchronous read buffers for W columns and x elements.
  always @(posedge clk) begin
    if (rd_en) begin
      w_rdata <= wbuf[rd_addr];
      x_rdata <= xbuf[rd_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [4:0]  ln;
    bit          fill;
    logic [71:0] w;
    logic [23:0] x;
    logic [23:0] exp;
    int          lat;
  } vec_t;

  task automatic load(input bit fill, input logic [71:0] w, input logic [23:0] x);
    for (int i = 0; i < 16; i++) begin
      wbuf[i] = fill ? 24'h010101 : 24'h5A5A5A;
      xbuf[i] = fill ? 8'h01 : 8'h33;
    end
    if (!fill) begin
      wbuf[0] = w[71:48]; wbuf[1] = w[47:24]; wbuf[2] = w[23:0];
      xbuf[0] = x[23:16]; xbuf[1] = x[15:8];  xbuf[2] = x[7:0];
    end
  endtask

  // Start a product, walk it to result_valid, check addresses, issues and latency.
  task automatic run_vec(input string tag, input logic [4:0] ln, input logic [23:0] exp, input int lat);
    int cyc = 0, addr_exp = 0, en_cnt = 0, n_exp;
    bit gap = 0;
    n_exp = (ln > 16) ? 16 : int'(ln);
    @(negedge clk); start = 1'b1; len = ln;
    @(negedge clk); start = 1'b0; cyc = 1;
    chk({tag, " clear"}, {31'd0, mac_clear}, 32'd1);
    while (!result_valid && cyc < 200) begin
      if (rd_en) begin
        if (rd_addr != addr_exp[3:0]) gap = 1;
        addr_exp++;
      end
      if (mac_enable) en_cnt++;
      @(negedge clk); cyc++;
    end
    chk({tag, " latency"}, cyc, lat);
    chk({tag, " rd count"}, addr_exp, n_exp);
    chk({tag, " addr gap"}, {31'd0, gap}, 32'd0);
    chk({tag, " issue count"}, en_cnt, n_exp);
    chk({tag, " result"}, {8'd0, result}, {8'd0, exp});
    chk({tag, " busy hold"}, {31'd0, busy}, 32'd1);
  endtask

  task automatic handshake(input string tag, input logic [23:0] exp);
    result_ready = 1'b1;
    @(negedge clk); result_ready = 1'b0;
    chk({tag, " valid drop"}, {31'd0, result_valid}, 32'd0);
    chk({tag, " idle"}, {31'd0, busy}, 32'd0);
    chk({tag, " result kept"}, {8'd0, result}, {8'd0, exp});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " busy"},   {31'd0, busy}, 32'd0);
    chk({tag, " rd_en"},  {31'd0, rd_en}, 32'd0);
    chk({tag, " rd_addr"}, {28'd0, rd_addr}, 32'd0);
    chk({tag, " clear"},  {31'd0, mac_clear}, 32'd0);
    chk({tag, " enable"}, {31'd0, mac_enable}, 32'd0);
    chk({tag, " mac_a"},  {8'd0, mac_a}, 32'd0);
    chk({tag, " mac_b"},  {24'd0, mac_b}, 32'd0);
    chk({tag, " result"}, {8'd0, result}, 32'd0);
    chk({tag, " valid"},  {31'd0, result_valid}, 32'd0);
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{"basic",  5'd3,  1'b0, {24'h010407, 24'h020508, 24'h030609}, 24'h010203, 24'h0E2032, 8};
    vecs[1] = '{"signed", 5'd3,  1'b0, {24'h010203, 24'h010203, 24'h03FA09}, 24'hFC04FD, 24'hF712E5, 8};
    vecs[2] = '{"len0",   5'd0,  1'b0, {24'h111111, 24'h222222, 24'h333333}, 24'h010101, 24'h000000, 5};
    vecs[3] = '{"len16",  5'd16, 1'b1, 72'd0, 24'd0, 24'h101010, 21};
    vecs[4] = '{"len17",  5'd17, 1'b1, 72'd0, 24'd0, 24'h101010, 21};

    reset_n = 1'b0; start = 1'b0; len = '0; result_ready = 1'b0;
    #2;
    chk_zero("por");
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      load(vecs[v].fill, vecs[v].w, vecs[v].x);
      run_vec(vecs[v].name, vecs[v].ln, vecs[v].exp, vecs[v].lat);
      handshake(vecs[v].name, vecs[v].exp);
    end

    // Backpressure: hold for five cycles with stray start pulses.
    load(vecs[0].fill, vecs[0].w, vecs[0].x);
    run_vec("bp", 5'd3, 24'h0E2032, 8);
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0); len = 5'd1;
      @(negedge clk);
      chk("bp result stable", {8'd0, result}, 32'h000E2032);
      chk("bp valid stable", {31'd0, result_valid}, 32'd1);
      chk("bp busy", {31'd0, busy}, 32'd1);
    end
    start = 1'b0;
    handshake("bp", 24'h0E2032);
    @(negedge clk);
    chk("bp no queued start", {31'd0, busy}, 32'd0);

    // Reset in the middle of STREAM, then a clean rerun.
    load(vecs[1].fill, vecs[1].w, vecs[1].x);
    @(negedge clk); start = 1'b1; len = 5'd3;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("mid issue active", {31'd0, mac_enable}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk_zero("midrst");
    @(negedge clk); reset_n = 1'b1;
    load(vecs[0].fill, vecs[0].w, vecs[0].x);
    run_vec("post rst", 5'd3, 24'h0E2032, 8);
    handshake("post rst", 24'h0E2032);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/vsmac_sequencer.md
Name: vsmac_sequencer

Overview:
Controller that drives one vsmac lane array through a full matrix-vector product y = W·x. W is SIZE rows by len columns, and x has len elements.
- On start, clears the vsmac accumulators, then streams len column/element pairs from two synchronous read buffers.
- Drains the vsmac pipeline, then holds the accumulated vector behind a valid/ready handshake.
- Sits between the layer-level control FSM and the vsmac datapath.

Parameters:
- SIZE, 3: vsmac lane count; matches vsmac SIZE.
- DATA_W, 8: signed lane width.
- K_MAX, 16: maximum column count.
- ADDR_W, 4: buffer address width, equal to clog2(K_MAX).
- PIPE_LAT, 2: cycles from a vsmac enable cycle until its contribution is visible on mac_out.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request a new product; sampled only in IDLE
- len  in  ADDR_W+1  column count, 0..K_MAX; latched on start
- busy  out  1  high in every state except IDLE
- rd_en  out  1  read strobe to both buffers
- rd_addr  out  ADDR_W  column index
- w_rdata  in  SIZE*DATA_W  weight column; valid the cycle after rd_en
- x_rdata  in  DATA_W  signed x element; valid the cycle after rd_en
- mac_clear  out  1  drives vsmac reset (synchronous, active-high)
- mac_enable  out  1  drives vsmac enable
- mac_a  out  SIZE*DATA_W  drives vsmac a
- mac_b  out  DATA_W  drives vsmac b
- mac_out  in  SIZE*DATA_W  vsmac out
- result  out  SIZE*DATA_W  captured product
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts result

Behaviour:
- Reset (asynchronous, reset_n low):
  - state returns to IDLE.
  - All outputs go to 0, including the result register and the counters.
  - Reset mid-operation abandons the product. The vsmac is not cleared until the next CLEAR state.
- States: IDLE, CLEAR, STREAM, DRAIN, HOLD.
- IDLE:
  - start=1 latches len; next state is CLEAR.
  - start outside IDLE is ignored, with no queuing.
- CLEAR: exactly 1 cycle with mac_clear=1.
  - Next state is STREAM if len>0, otherwise DRAIN.
- STREAM: len cycles.
  - rd_en=1 and rd_addr=0,1,..,len-1 on consecutive cycles.
  - Next state is DRAIN after the cycle with rd_addr=len-1.
- Issue alignment:
  - mac_enable is rd_en delayed one cycle through a register.
  - While mac_enable=1: mac_a=w_rdata and mac_b=x_rdata, combinational pass-through.
  - While mac_enable=0: mac_a=0 and mac_b=0.
- DRAIN: runs 1+PIPE_LAT cycles, covering the last issue cycle plus PIPE_LAT.
  - On the final DRAIN cycle, result<=mac_out and result_valid<=1; next state is HOLD.
  - For len=0, the drain count is identical and result is 0, coming from the cleared vsmac.
- HOLD:
  - result and result_valid are held stable.
  - result_valid&&result_ready leads to IDLE next cycle with result_valid=0. result keeps its last value.
  - busy=1 until the handshake completes; start is ignored.
- Latency: start accepted at cycle 0 gives CLEAR at cycle 1.
  - Issue occurs at cycles 3..len+2.
  - result_valid rises at cycle len+3+PIPE_LAT.
  - Example: len=3, PIPE_LAT=2 gives result_valid at cycle 8.
- Back-to-back: the earliest new start is the cycle after the handshake cycle.
- Width and saturation:
  - len values above K_MAX are clamped to K_MAX.
  - No arithmetic happens in this block; overflow wrap is the vsmac's concern.

Decomposition:
- Shared package vsmac_pkg holds:
  - DATA_W.
  - The state encoding typedef (5 states).
  - The SIZE default, shared with vsmac.
- Natural sub-module: delay_line (parameterised DEPTH and WIDTH shift register) for the rd_en to mac_enable alignment. It is reusable by the other sequencers.
- The bench instantiates the real vsmac with PIPE_LAT matched to it.

Test Plan:
1. Basic product:
   - Stimulus: len=3; columns [01,04,07], [02,05,08], [03,06,09]; x=[01,02,03].
   - Required: result=24'h0E2032, with result_valid rising exactly at cycle 8 after start.
2. Signed product:
   - Stimulus: len=3; columns 010203, 010203, 03FA09; x=[FC,04,FD].
   - Required: result=24'hF712E5.
3. Backpressure:
   - Stimulus: result_ready held low for 5 cycles in HOLD.
   - Required: result and result_valid stable; start pulses ignored; IDLE entered one cycle after ready rises.
4. len=0:
   - Required: no rd_en and no mac_enable; result=0; result_valid at cycle 3+PIPE_LAT.
5. Reset mid-STREAM:
   - Stimulus: reset_n asserted at cycle 4.
   - Required: all outputs 0 immediately; state IDLE.
   - Follow-up: a new len=3 start then yields 0E2032, confirming no stale accumulation.
6. len=K_MAX=16:
   - Stimulus: all columns 010101, x=01.
   - Required: rd_addr runs 0..15 with no gaps; result=24'h101010. A len=17 request behaves identically.
